// File: rtl/add_rr_sched.sv
// add_rr_sched: round-robin scheduler that shares one add datapath
// between NUM_REQ requesters.
//
// One transaction is in flight at a time. The FSM runs IDLE -> ISSUE -> RESP.
//   IDLE  : grant the first requester with req_valid set, searching upward
//           from ptr. The chosen requester's operands are latched.
//   ISSUE : drive the latched operands to the adder. The sum is captured once
//           both din channels and dout complete a handshake.
//   RESP  : present the sum to the granted requester until it accepts.
//
// Ports
//   clk, rst                  clock and synchronous active-low reset
//   req_valid/req_ready       per-requester operand handshake
//                             (req_ready is one-hot or zero)
//   req_data                  slice i = {op1[W1], op0[W0]}
//   resp_valid/resp_ready     per-requester result handshake
//                             (resp_valid is one-hot or zero)
//   resp_data                 shared result bus
//   add_din0_*/add_din1_*     operand channels to the shared adder
//   add_dout_*                result channel from the shared adder
//   grant_id, busy            current grant index and activity flag
module add_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int W0      = 16,
    parameter int W1      = 16,
    parameter int WOUT    = 17,
    localparam int GW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*(W0+W1)-1:0] req_data,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [WOUT-1:0]           resp_data,
    output logic [W0-1:0]             add_din0_data,
    output logic                      add_din0_valid,
    input  logic                      add_din0_ready,
    output logic [W1-1:0]             add_din1_data,
    output logic                      add_din1_valid,
    input  logic                      add_din1_ready,
    input  logic [WOUT-1:0]           add_dout_data,
    input  logic                      add_dout_valid,
    output logic                      add_dout_ready,
    output logic [GW-1:0]             grant_id,
    output logic                      busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]      state;
    logic [GW-1:0]   ptr;
    logic [W0-1:0]   op0_p0;
    logic [W1-1:0]   op1_p0;
    logic [WOUT-1:0] sum_p1;

    logic            found;
    logic [GW-1:0]   win;
    logic [GW:0]     cand;
    logic [W0-1:0]   sel_op0;
    logic [W1-1:0]   sel_op1;
    logic            add_fire;

    // Round-robin search: the first requester at or above ptr wins,
    // wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[GW-1:0]]) begin
                found = 1'b1;
                win   = cand[GW-1:0];
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_op0 = '0;
        sel_op1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == GW'(i)) begin
                sel_op0 = req_data[i*(W0+W1) +: W0];
                sel_op1 = req_data[i*(W0+W1)+W0 +: W1];
            end
        end
    end

    // Per-requester handshake strobes. Both are one-hot or zero.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = (state == S_IDLE) && found && (win == GW'(i));
            resp_valid[i] = (state == S_RESP) && (grant_id == GW'(i));
        end
    end

    assign add_fire       = add_dout_valid && add_din0_ready && add_din1_ready;
    assign add_din0_valid = (state == S_ISSUE);
    assign add_din1_valid = (state == S_ISSUE);
    assign add_dout_ready = (state == S_ISSUE);
    assign add_din0_data  = op0_p0;
    assign add_din1_data  = op1_p0;
    assign resp_data      = sum_p1;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant_id <= '0;
            op0_p0   <= '0;
            op1_p0   <= '0;
            sum_p1   <= '0;
        end else begin
            case (state)
                // p0: request accepted, operands latched
                S_IDLE: begin
                    if (found) begin
                        op0_p0   <= sel_op0;
                        op1_p0   <= sel_op1;
                        grant_id <= win;
                        ptr      <= (win == GW'(NUM_REQ-1)) ? '0 : win + 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                // p1: adder handshake, sum captured unmodified
                S_ISSUE: begin
                    if (add_fire) begin
                        sum_p1 <= add_dout_data;
                        state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready[grant_id]) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
